// File: rtl/t09_sound_scheduler.sv
// Sound scheduler: latches bad/good/button requests and plays one square-wave tone at a time, bad > good > button, with a silent gap after each.
// Optional macro SOUND_PREEMPT_EN lets a bad request abort a good or button tone and play at once.
module t09_sound_scheduler #(
    parameter int DUR_CYCLES = 2500000,
    parameter int GAP_CYCLES = 250000,
    parameter int GOOD_DIV   = 11363,
    parameter int BAD_DIV    = 22727,
    parameter int BTN_DIV    = 7575
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       goodColl,
    input  logic       badColl,
    input  logic       button,
    output logic       soundOut,
    output logic       busy,
    output logic [1:0] toneId
);
    localparam int DIV_MAX = (BAD_DIV > GOOD_DIV) ? ((BAD_DIV > BTN_DIV) ? BAD_DIV : BTN_DIV)
                                                  : ((GOOD_DIV > BTN_DIV) ? GOOD_DIV : BTN_DIV);
    localparam int DUR_W = (DUR_CYCLES > 1) ? $clog2(DUR_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int DIV_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [1:0] TONE_NONE = 2'b00;
    localparam logic [1:0] TONE_BTN  = 2'b01;
    localparam logic [1:0] TONE_GOOD = 2'b10;
    localparam logic [1:0] TONE_BAD  = 2'b11;

    logic [1:0]       state;
    logic             pend_bad;
    logic             pend_good;
    logic             pend_btn;
    logic [DUR_W-1:0] dur_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_last;
    logic [1:0]       idle_pick;
    logic [1:0]       gap_pick;
    logic             dur_done;
    logic             gap_done;
    logic             div_wrap;
    logic             preempt;

    function automatic logic [1:0] pick(input logic b, input logic g, input logic n);
        logic [1:0] t;
        t = TONE_NONE;
        if (b)
            t = TONE_BAD;
        else if (g)
            t = TONE_GOOD;
        else if (n)
            t = TONE_BTN;
        return t;
    endfunction

    // IDLE also looks at this cycle's inputs so a request is granted on the very next edge
    assign idle_pick = pick(pend_bad | badColl, pend_good | goodColl, pend_btn | button);
    assign gap_pick  = pick(pend_bad, pend_good, pend_btn);

    always_comb begin
        div_last = DIV_W'(BTN_DIV - 1);
        case (toneId)
            TONE_GOOD: div_last = DIV_W'(GOOD_DIV - 1);
            TONE_BAD:  div_last = DIV_W'(BAD_DIV - 1);
            default:   div_last = DIV_W'(BTN_DIV - 1);
        endcase
    end

    assign dur_done = (dur_cnt == DUR_W'(DUR_CYCLES - 1));
    assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign div_wrap = (div_cnt == div_last);
    assign busy     = (state != IDLE);

`ifdef SOUND_PREEMPT_EN
    assign preempt = (state == PLAY) && (toneId != TONE_BAD) && badColl;
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend_bad  <= 1'b0;
            pend_good <= 1'b0;
            pend_btn  <= 1'b0;
            dur_cnt   <= '0;
            gap_cnt   <= '0;
            div_cnt   <= '0;
            soundOut  <= 1'b0;
            toneId    <= TONE_NONE;
        end else begin
            pend_bad  <= pend_bad | badColl;
            pend_good <= pend_good | goodColl;
            pend_btn  <= pend_btn | button;
            case (state)
                IDLE: begin
                    if (idle_pick != TONE_NONE) begin
                        state    <= PLAY;
                        toneId   <= idle_pick;
                        dur_cnt  <= '0;
                        div_cnt  <= '0;
                        soundOut <= 1'b0;
                        // the granted request, flag or live input, is consumed here
                        case (idle_pick)
                            TONE_BAD:  pend_bad  <= 1'b0;
                            TONE_GOOD: pend_good <= 1'b0;
                            default:   pend_btn  <= 1'b0;
                        endcase
                    end
                end
                PLAY: begin
                    if (preempt) begin
                        toneId   <= TONE_BAD;
                        dur_cnt  <= '0;
                        div_cnt  <= '0;
                        soundOut <= 1'b0;
                        pend_bad <= 1'b0;
                        if (toneId == TONE_GOOD)
                            pend_good <= 1'b1;
                        else
                            pend_btn <= 1'b1;
                    end else if (dur_done) begin
                        state    <= GAP;
                        toneId   <= TONE_NONE;
                        soundOut <= 1'b0;
                        gap_cnt  <= '0;
                    end else begin
                        dur_cnt <= dur_cnt + 1'b1;
                        if (div_wrap) begin
                            div_cnt  <= '0;
                            soundOut <= ~soundOut;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        if (gap_pick != TONE_NONE) begin
                            state    <= PLAY;
                            toneId   <= gap_pick;
                            dur_cnt  <= '0;
                            div_cnt  <= '0;
                            soundOut <= 1'b0;
                            // a fresh request on the granting edge keeps the flag set
                            case (gap_pick)
                                TONE_BAD:  pend_bad  <= badColl;
                                TONE_GOOD: pend_good <= goodColl;
                                default:   pend_btn  <= button;
                            endcase
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    toneId <= TONE_NONE;
                end
            endcase
        end
    end
endmodule
